// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and constants for the multi-port register file.
//            - state_t / ST_INIT / ST_READY : sweep-controller state encoding
//            - REG_ZERO                     : index of the hardwired-zero reg
//            - clog2()                      : address-width helper
// Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

    // Controller state, encoded explicitly on a 1-bit vector.
    typedef logic [0:0] state_t;
    localparam state_t ST_INIT  = 1'b0;
    localparam state_t ST_READY = 1'b1;

    // Index of the architectural zero register.
    localparam int REG_ZERO = 0;

    // Ceiling log2, used to derive the address width from the register count.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_port
// Purpose  : One combinational read port of regfile_mp: register mux, busy
//            mux, zero-register mask and optional write-through bypass.
// Ports    : i_regs     storage array (all registers)
//            i_busy     pending-write bit per register
//            i_addr     register being read
//            i_ready    file is initialised (bypass only valid then)
//            i_wr_en    writeback strobe      (bypass source)
//            i_wr_addr  writeback address     (bypass source)
//            i_wr_data  writeback data        (bypass source)
//            o_data     read data
//            o_busy     pending-write flag for i_addr
// Config   : REGFILE_MP_BYPASS_EN  enables same-cycle write-through
// Revision : 1.0  initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = clog2(NREGS)
) (
    input  logic [NREGS-1:0][XLEN-1:0] i_regs,
    input  logic [NREGS-1:0]           i_busy,
    input  logic [AW-1:0]              i_addr,
    input  logic                       i_ready,
    input  logic                       i_wr_en,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [XLEN-1:0]            i_wr_data,
    output logic [XLEN-1:0]            o_data,
    output logic                       o_busy
);

    localparam logic [AW-1:0] c_ZERO_ADDR = AW'(REG_ZERO);

    logic w_is_zero;
    logic w_bypass;

`ifdef REGFILE_MP_BYPASS_EN
    // Forward the write that is landing this cycle; a write retires the
    // pending destination, so the forwarded value is never busy.
    assign w_bypass = i_ready && i_wr_en && !w_is_zero && (i_wr_addr == i_addr);
`else
    // Without bypass the writeback inputs are not observed by the port.
    logic w_unused_bypass;
    assign w_unused_bypass = ^{i_ready, i_wr_en, i_wr_addr, i_wr_data};
    assign w_bypass        = 1'b0;
`endif

    always_comb begin
        w_is_zero = (i_addr == c_ZERO_ADDR);
        o_data    = i_regs[i_addr];
        o_busy    = i_busy[i_addr];
        // Zero register reads as zero regardless of what the sweep stored.
        if (w_is_zero) begin
            o_data = '0;
            o_busy = 1'b0;
        end else if (w_bypass) begin
            o_data = i_wr_data;
            o_busy = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-read-port integer register file with
//            hardwired x0, init/clear sweep controller and per-register
//            pending-write (busy) scoreboard. Single write port.
// Ports    : clock       rising-edge clock
//            reset       asynchronous, active-low reset
//            rs_addr     read addresses, port p at [p*AW +: AW]
//            rs_data     read data, port p at [p*XLEN +: XLEN]
//            rs_busy     per-port pending-write flag
//            alloc_en    claim alloc_addr as pending destination
//            alloc_addr  destination being claimed
//            wr_en       writeback strobe
//            wr_addr     writeback address
//            wr_data     writeback data
//            clear_req   request a full re-initialisation sweep
//            ready       file initialised and accepting traffic
//            wr_drop     1-cycle pulse: a write/alloc arrived during the sweep
// Config   : REGFILE_MP_BYPASS_EN  same-cycle write-through on read ports
// Revision : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int INIT_IDX = 1,
    localparam int AW      = clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                clear_req,
    output logic                ready,
    output logic                wr_drop
);

    localparam logic [AW-1:0] c_ZERO_ADDR = AW'(REG_ZERO);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(NREGS - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [AW-1:0]              r_cnt;
    logic [NREGS-1:0][XLEN-1:0] r_mem;
    logic [NREGS-1:0]           r_busy;
    logic                       r_wr_drop;

    logic                       w_ready;
    logic                       w_wr_ok;
    logic                       w_alloc_ok;
    logic                       w_req_drop;
    logic                       w_sweep_done;
    logic [XLEN-1:0]            w_init_val;

    always_comb begin
        w_ready      = (r_state == ST_READY);
        w_wr_ok      = w_ready && wr_en && (wr_addr != c_ZERO_ADDR);
        w_alloc_ok   = w_ready && alloc_en && (alloc_addr != c_ZERO_ADDR);
        // Traffic aimed at x0 is discarded silently, even during the sweep.
        w_req_drop   = !w_ready && ((wr_en && (wr_addr != c_ZERO_ADDR)) ||
                                    (alloc_en && (alloc_addr != c_ZERO_ADDR)));
        w_sweep_done = (r_cnt == c_LAST_ADDR);
        w_init_val   = (INIT_IDX != 0) ? XLEN'(r_cnt) : '0;
    end

    // Next-state logic: clear_req only matters once the file is ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  if (w_sweep_done) w_state_nxt = ST_READY;
            ST_READY: if (clear_req)    w_state_nxt = ST_INIT;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_busy    <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_drop <= w_req_drop;
            // The counter wraps to zero after the last register because
            // NREGS is a power of two; it is held at zero while ready so a
            // clear always restarts the sweep from register 0.
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + AW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_ready && clear_req) begin
                r_busy <= '0;
            end else begin
                // Alloc is applied last so it wins over a same-cycle write.
                if (w_wr_ok)    r_busy[wr_addr]    <= 1'b0;
                if (w_alloc_ok) r_busy[alloc_addr] <= 1'b1;
            end
        end
    end

    // Storage has no reset; contents are established by the sweep.
    always_ff @(posedge clock) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= w_init_val;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd (
            .i_regs    (r_mem),
            .i_busy    (r_busy),
            .i_addr    (rs_addr[p*AW +: AW]),
            .i_ready   (w_ready),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_data    (rs_data[p*XLEN +: XLEN]),
            .o_busy    (rs_busy[p])
        );
    end

    assign ready   = w_ready;
    assign wr_drop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp (XLEN=64, NREGS=32, NRD=2,
//            INIT_IDX=1). Table of single-cycle vectors plus hand-written
//            sequences for bypass, clear sweep and mid-sweep reset.
// Config   : REGFILE_MP_BYPASS_EN  selects the expected same-cycle read
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int c_XLEN  = 64;
    localparam int c_NREGS = 32;
    localparam int c_NRD   = 2;
    localparam int c_AW    = 5;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [c_NRD*c_AW-1:0]   rs_addr = '0;
    logic [c_NRD*c_XLEN-1:0] rs_data;
    logic [c_NRD-1:0]        rs_busy;
    logic                    alloc_en = 1'b0;
    logic [c_AW-1:0]         alloc_addr = '0;
    logic                    wr_en = 1'b0;
    logic [c_AW-1:0]         wr_addr = '0;
    logic [c_XLEN-1:0]       wr_data = '0;
    logic                    clear_req = 1'b0;
    logic                    ready;
    logic                    wr_drop;

    always #5 clock = ~clock;

    regfile_mp #(
        .XLEN     (c_XLEN),
        .NREGS    (c_NREGS),
        .NRD      (c_NRD),
        .INIT_IDX (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .ready      (ready),
        .wr_drop    (wr_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected read-port results.
    typedef struct {
        string       name;
        int          port;
        logic [63:0] data;
        logic        busy;
    } exp_t;
    exp_t sb[$];

    task automatic sb_push(input string name, input int port, input logic [63:0] d, input logic b);
        exp_t e;
        e.name = name;
        e.port = port;
        e.data = d;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, "_data"}, rs_data[e.port*c_XLEN +: c_XLEN], e.data);
            chk({e.name, "_busy"}, 64'(rs_busy[e.port]), 64'(e.busy));
        end
    endtask

    // Counts rising edges until ready, bounded.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        b0;
        logic        b1;
        logic        drop;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        //            we  wa     wd               ae  aa     a0     a1     d0               d1               b0 b1 drop
        vecs[0] = '{1'b0, 5'd0,  64'h0,           1'b0, 5'd0,  5'd5,  5'd0,  64'd5,           64'd0,           1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 5'd3,  64'hDEAD_BEEF,   1'b0, 5'd0,  5'd0,  5'd3,  64'd0,           64'hDEAD_BEEF,   1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  64'h1234,        1'b0, 5'd0,  5'd0,  5'd3,  64'd0,           64'hDEAD_BEEF,   1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  64'h0,           1'b1, 5'd7,  5'd7,  5'd3,  64'd7,           64'hDEAD_BEEF,   1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd7,  64'h55,          1'b0, 5'd0,  5'd7,  5'd7,  64'h55,          64'h55,          1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd7,  64'h77,          1'b1, 5'd7,  5'd7,  5'd0,  64'h77,          64'd0,           1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 5'd0,  64'h0,           1'b1, 5'd7,  5'd7,  5'd3,  64'h77,          64'hDEAD_BEEF,   1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 5'd0,  64'h0,           1'b1, 5'd0,  5'd0,  5'd7,  64'd0,           64'h77,          1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 5'd12, 64'hA5A5,        1'b1, 5'd20, 5'd12, 5'd20, 64'hA5A5,        64'd20,          1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 5'd20, 64'h1,           1'b0, 5'd0,  5'd31, 5'd20, 64'd31,          64'd1,           1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_drop",  64'(wr_drop), 64'd0);
        chk("rst_busy",  64'(rs_busy), 64'd0);

        // Initial sweep latency.
        @(negedge clock);
        reset = 1'b1;
        wait_ready(cyc);
        chk("init_latency", 64'(cyc), 64'd32);

        // Table-driven single-cycle operations.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            wr_en      = vecs[i].we;
            wr_addr    = vecs[i].wa;
            wr_data    = vecs[i].wd;
            alloc_en   = vecs[i].ae;
            alloc_addr = vecs[i].aa;
            rs_addr    = {vecs[i].a1, vecs[i].a0};
            sb_push($sformatf("v%0d_p0", i), 0, vecs[i].d0, vecs[i].b0);
            sb_push($sformatf("v%0d_p1", i), 1, vecs[i].d1, vecs[i].b1);
            @(posedge clock);
            #1;
            wr_en    = 1'b0;
            alloc_en = 1'b0;
            #1;
            sb_check();
            chk($sformatf("v%0d_drop", i), 64'(wr_drop), 64'(vecs[i].drop));
        end

        // Same-cycle write vs read (bypass or old value).
        @(negedge clock);
        alloc_en   = 1'b1;
        alloc_addr = 5'd9;
        @(posedge clock);
        #1;
        alloc_en = 1'b0;
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 64'hAB;
        rs_addr = {5'd0, 5'd9};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        sb_push("byp_same", 0, 64'hAB, 1'b0);
`else
        sb_push("byp_same", 0, 64'd9, 1'b1);
`endif
        sb_check();
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        #1;
        sb_push("byp_after", 0, 64'hAB, 1'b0);
        sb_check();

        // Clear sweep with a dropped write.
        @(negedge clock);
        clear_req = 1'b1;
        rs_addr   = {5'd3, 5'd7};
        @(posedge clock);
        #1;
        clear_req = 1'b0;
        chk("clr_ready", 64'(ready), 64'd0);
        sb_push("clr_p0", 0, 64'h77, 1'b0);
        sb_check();
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 64'hFFFF;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        chk("clr_drop_pulse", 64'(wr_drop), 64'd1);
        @(posedge clock);
        #1;
        chk("clr_drop_end", 64'(wr_drop), 64'd0);
        wait_ready(cyc);
        chk("clr_latency", 64'(cyc + 2), 64'd32);
        sb_push("clr_reg7", 0, 64'd7, 1'b0);
        sb_push("clr_reg3", 1, 64'd3, 1'b0);
        sb_check();

        // Reset in the middle of a sweep.
        @(negedge clock);
        wr_en      = 1'b1;
        wr_addr    = 5'd25;
        wr_data    = 64'hBAD;
        alloc_en   = 1'b1;
        alloc_addr = 5'd5;
        rs_addr    = {5'd25, 5'd5};
        @(posedge clock);
        #1;
        wr_en    = 1'b0;
        alloc_en = 1'b0;
        #1;
        sb_push("pre_reg5", 0, 64'd5, 1'b1);
        sb_push("pre_reg25", 1, 64'hBAD, 1'b0);
        sb_check();
        @(negedge clock);
        clear_req = 1'b1;
        @(posedge clock);
        #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'd0);
        chk("mid_rst_busy", 64'(rs_busy), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wait_ready(cyc);
        chk("mid_rst_latency", 64'(cyc), 64'd32);
        sb_push("post_reg5", 0, 64'd5, 1'b0);
        sb_push("post_reg25", 1, 64'd25, 1'b0);
        sb_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
